// File: rtl/mips_run_ctrl.sv
// Run-control unit for the single-cycle MIPS core: reset hold sequencing, run/halt/step
// commands, PC breakpoints with skip-once resume, and a saturating executed-cycle counter.
module mips_run_ctrl #(
  parameter int PC_W      = 32,
  parameter int NUM_BP    = 2,
  parameter int RST_HOLD  = 4,
  parameter int START_RUN = 0,
  parameter int CNT_W     = 32,
  localparam int IDX_W    = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [15:0]       cmd_arg,
  input  logic              bp_we,
  input  logic [IDX_W-1:0]  bp_idx,
  input  logic [PC_W-1:0]   bp_addr,
  input  logic              bp_en,
  input  logic [PC_W-1:0]   pc,
  output logic              core_rst,
  output logic              core_ce,
  output logic [1:0]        state,
  output logic [NUM_BP-1:0] bp_hit,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [15:0]       step_left
);

  localparam int HOLD_W = (RST_HOLD < 2) ? 1 : $clog2(RST_HOLD + 1);

  typedef enum logic [1:0] {
    S_RESET = 2'b00,
    S_HALT  = 2'b01,
    S_RUN   = 2'b10,
    S_STEP  = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    OP_RUN        = 2'b00,
    OP_HALT       = 2'b01,
    OP_STEP       = 2'b10,
    OP_RESET_CORE = 2'b11
  } op_t;

  state_t              state_q;
  logic [HOLD_W-1:0]   hold_q;
  logic                skip_q;
  logic [PC_W-1:0]     bp_addr_q [NUM_BP];
  logic [NUM_BP-1:0]   bp_en_q;
  logic [NUM_BP-1:0]   match;
  logic                active;
  logic                bp_stop;
  logic                cmd_fire;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    match = '0;
    for (int i = 0; i < NUM_BP; i++) begin
      match[i] = bp_en_q[i] && (pc == bp_addr_q[i]);
    end
    active    = (state_q == S_RUN) || (state_q == S_STEP);
    bp_stop   = active && !skip_q && (|match);
    core_ce   = active && !bp_stop;
    cmd_ready = (state_q != S_RESET);
    cmd_fire  = cmd_valid && cmd_ready;
  end

  assign state = state_q;

  // NOTE: sequential state uses non-blocking assignments only; within this block a later
  // assignment to the same register overrides an earlier one, which is how commands win.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_RESET;
      hold_q    <= HOLD_W'(RST_HOLD);
      skip_q    <= 1'b0;
      core_rst  <= 1'b1;
      cycle_cnt <= '0;
      bp_hit    <= '0;
      step_left <= '0;
      bp_en_q   <= '0;
      // NOTE: the small breakpoint address file is reset too, so matching never sees X.
      for (int i = 0; i < NUM_BP; i++) bp_addr_q[i] <= '0;
    end else begin
      skip_q <= 1'b0;

      if (bp_we && (int'(bp_idx) < NUM_BP)) begin
        bp_addr_q[bp_idx] <= bp_addr;
        bp_en_q[bp_idx]   <= bp_en;
      end

      if (core_ce && (cycle_cnt != '1)) cycle_cnt <= cycle_cnt + CNT_W'(1);

      case (state_q)
        S_RESET: begin
          if (hold_q <= HOLD_W'(1)) begin
            core_rst <= 1'b0;
            state_q  <= (START_RUN != 0) ? S_RUN : S_HALT;
          end else begin
            hold_q <= hold_q - HOLD_W'(1);
          end
        end
        S_RUN, S_STEP: begin
          if (bp_stop) begin
            state_q <= S_HALT;
            bp_hit  <= bp_hit | match;
          end else if (state_q == S_STEP && step_left != 16'd0) begin
            step_left <= step_left - 16'd1;
            if (step_left == 16'd1) state_q <= S_HALT;
          end
        end
        default: ;
      endcase

      if (cmd_fire) begin
        case (op_t'(cmd_op))
          OP_RUN: begin
            state_q <= S_RUN;
            bp_hit  <= '0;
            skip_q  <= 1'b1;
          end
          OP_HALT: begin
            state_q <= S_HALT;
            bp_hit  <= bp_hit;
          end
          OP_STEP: begin
            state_q   <= S_STEP;
            step_left <= (cmd_arg == 16'd0) ? 16'd1 : cmd_arg;
            bp_hit    <= '0;
            skip_q    <= 1'b1;
          end
          OP_RESET_CORE: begin
            state_q   <= S_RESET;
            core_rst  <= 1'b1;
            hold_q    <= HOLD_W'(RST_HOLD);
            cycle_cnt <= '0;
            bp_hit    <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/mips_run_ctrl.md
# mips_run_ctrl

Run-control unit for the single-cycle MIPS core. It sits between the system clock/reset and the `mips` instance, and replaces free-running reset-and-go bring-up with a controlled sequence: a programmable reset hold, then run/halt/single-step commands, PC breakpoints and an executed-cycle counter. It drives the core's `rst` and a clock-enable; the core's `PC` output feeds back for breakpoint matching.

## Interface
- `PC_W`, default 32: width of the PC and breakpoint addresses.
- `NUM_BP`, default 2: number of breakpoint comparators (1..8).
- `RST_HOLD`, default 4: number of cycles `core_rst` stays high after any reset entry (≥1).
- `START_RUN`, default 0: 1 = enter RUN after reset hold, 0 = enter HALT.
- `CNT_W`, default 32: width of the cycle counter.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low block reset.
- `cmd_valid`  in  1  command strobe.
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`.
- `cmd_op`  in  2  00 RUN, 01 HALT, 10 STEP, 11 RESET_CORE.
- `cmd_arg`  in  16  step count for STEP; ignored otherwise.
- `bp_we`  in  1  breakpoint register write.
- `bp_idx`  in  max(1,$clog2(NUM_BP))  breakpoint slot; writes to out-of-range slots are ignored.
- `bp_addr`  in  PC_W  breakpoint address.
- `bp_en`  in  1  breakpoint enable written with the address.
- `pc`  in  PC_W  current core PC.
- `core_rst`  out  1  active-high reset to the core.
- `core_ce`  out  1  core clock-enable; the core executes one instruction on each edge where it is high.
- `state`  out  2  00 RESET, 01 HALT, 10 RUN, 11 STEP.
- `bp_hit`  out  NUM_BP  sticky per-slot hit flags.
- `cycle_cnt`  out  CNT_W  count of edges with `core_ce` = 1; saturates.
- `step_left`  out  16  remaining STEP cycles.

## Operation
- **Block reset (`rst` = 0).** The block asynchronously enters RESET.
  - `core_rst`=1, `cycle_cnt`=0, `bp_hit`=0, `step_left`=0.
  - All breakpoint enables are cleared. The hold counter is loaded with RST_HOLD.
- **RESET state.**
  - `cmd_ready`=0 and `core_ce`=0.
  - The hold counter decrements each edge. At zero: `core_rst`←0 and the state moves to RUN if START_RUN=1, otherwise HALT.
- **HALT state.** `core_ce`=0.
- **RUN state.** `core_ce`=1 unless a breakpoint matches.
- **STEP state.**
  - `core_ce`=1 unless a breakpoint matches.
  - On each executed edge, `step_left` decrements. When `step_left` reaches 0 on that edge, the state moves to HALT.
- **Commands.** `cmd_ready`=1 in every state except RESET.
  - RUN: state←RUN.
  - HALT: state←HALT.
  - STEP: state←STEP and `step_left`←`cmd_arg`; an argument of 0 is treated as 1.
  - RESET_CORE: enter RESET with a fresh RST_HOLD. Clears `cycle_cnt` and `bp_hit`. Breakpoint registers are kept.
  - RUN, STEP and RESET_CORE all clear `bp_hit`.
- **Breakpoints.**
  - A slot matches when it is enabled and `pc` == its address. Match is evaluated combinationally.
  - In RUN or STEP, any match forces `core_ce`=0 for that cycle. The state moves to HALT, the matching `bp_hit` bits are set, and `step_left` is unchanged.
- **Skip-once.** The first cycle after an accepted RUN or STEP ignores breakpoints. This lets the core resume from a breakpointed PC.
- **Priority.** An accepted command takes priority over a same-cycle breakpoint halt or step completion. In that case `bp_hit` is not set by that cycle.
- **Breakpoint writes.** `bp_we` is honoured in every state, including RESET. A write takes effect for matching on the next cycle.
- **Counter.** `cycle_cnt` increments on every edge with `core_ce`=1 and holds at all-ones.

## Timing
- **Registered outputs.** `state`, `core_rst`, `bp_hit`, `cycle_cnt` and `step_left` are registered.
- **Combinational outputs.**
  - `core_ce` is combinational from `state`, the skip flag and the breakpoint match.
  - `cmd_ready` is combinational from `state`.
- **After `rst` rises.**
  - `core_rst` remains 1 for exactly RST_HOLD rising edges, then falls.
  - `core_ce` can first be 1 in the cycle after that, and only if START_RUN=1.
- **Command latency.** A command accepted at edge k changes `state` at edge k. For RUN/STEP, `core_ce`=1 during cycle k..k+1; the first instruction executes at edge k+1.
- **STEP N from HALT.** Produces exactly N cycles with `core_ce`=1, absent breakpoints. The state is HALT after the N-th executing edge.
- **Breakpoint halt.** Zero-latency: the matching instruction is never executed.
- **Mid-operation reset.** `rst` asserted during RUN or STEP aborts immediately with no extra `core_ce` cycle. `cmd_valid` is ignored while `rst`=0.

## Test plan
- **Reset hold.** RST_HOLD=4, START_RUN=0. Release `rst` → `core_rst` high for 4 edges, then state=HALT, `core_ce`=0, `cycle_cnt`=0.
- **Step.** STEP with `cmd_arg`=3 from HALT → exactly 3 `core_ce` pulses, `step_left` 3→2→1→0, state=HALT, `cycle_cnt`=3. STEP with `cmd_arg`=0 → exactly 1 pulse.
- **Breakpoint and resume.** Set bp0=0x0000_0010 (enabled), then RUN.
  - When `pc`=0x10: `core_ce`=0, state=HALT, `bp_hit`=01.
  - A following RUN clears `bp_hit` and executes at 0x10 (skip-once).
- **Command vs. breakpoint collision.** A HALT command in the same cycle as a bp match → state=HALT, `bp_hit` stays 0. A STEP in the same cycle as a bp match → state=STEP with the new count.
- **RESET_CORE.** RESET_CORE during RUN with `cycle_cnt`=100 → `core_rst`=1 for RST_HOLD edges and `cycle_cnt`=0. Breakpoints still match afterwards.
- **Async reset and saturation.**
  - `rst` low mid-STEP (`step_left`=5) → immediate RESET, `step_left`=0, bp enables cleared.
  - With CNT_W=4, 20 RUN cycles → `cycle_cnt`=15.
